ram_transfer_engine: RTL

- Responder side of the cmd_transfer / interupt_ram_transfer handshake used by the ECC controllers (scalar multiplication, point add, point double).
- On each accepted command it copies one multi-word operand:
  - from outer RAM to inner RAM (load), or
  - from inner RAM to outer RAM (store).
- It then pulses interupt_ram_transfer for one cycle.
- It sits between the controllers and the two RAMs' read/write ports.

---
 rtl/ram_transfer_engine.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ram_transfer_engine.sv
// Copies one WORDS-long operand between outer and inner RAM per accepted rising edge of cmd_transfer.
// Word k is read at cycle 2k+1 and written at 2k+2, with the interrupt at 2*WORDS+1; edges arriving while busy are dropped and flagged.
module ram_transfer_engine #(
    parameter int WORD_W = 64,
    parameter int WORDS  = 3,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_transfer,
    input  logic              read_write_command,
    input  logic [ADDR_W-1:0] read_address,
    input  logic [ADDR_W-1:0] write_address,
    output logic              interupt_ram_transfer,
    output logic              busy,
    output logic              cmd_overrun,
    output logic [ADDR_W-1:0] outer_ram_addr,
    output logic              outer_ram_re,
    output logic              outer_ram_we,
    output logic [WORD_W-1:0] outer_ram_wdata,
    input  logic [WORD_W-1:0] outer_ram_rdata,
    output logic [ADDR_W-1:0] inner_ram_addr,
    output logic              inner_ram_re,
    output logic              inner_ram_we,
    output logic [WORD_W-1:0] inner_ram_wdata,
    input  logic [WORD_W-1:0] inner_ram_rdata
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state, state_nxt;
    logic              cmd_prev;
    logic              dir, dir_nxt;
    logic [ADDR_W-1:0] src, src_nxt;
    logic [ADDR_W-1:0] dst, dst_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic              busy_nxt, irq_nxt, overrun_nxt;
    logic [ADDR_W-1:0] outer_addr_nxt, inner_addr_nxt;
    logic              outer_re_nxt, outer_we_nxt, inner_re_nxt, inner_we_nxt;
    logic              issue_rd, issue_wr, op_dir;
    logic [ADDR_W-1:0] op_addr;
    logic [WORD_W-1:0] wdata_q, src_rdata, wdata;
    logic              cmd_rise, accept;

    assign cmd_rise  = cmd_transfer & ~cmd_prev;
    assign accept    = cmd_rise & (state == IDLE);
    assign src_rdata = dir ? inner_ram_rdata : outer_ram_rdata;

    // Read data arrives the cycle after re, so WRITE forwards it straight through;
    // outside WRITE the bus shows the last word written.
    assign wdata           = (state == WRITE) ? src_rdata : wdata_q;
    assign outer_ram_wdata = wdata;
    assign inner_ram_wdata = wdata;

    always_comb begin
        state_nxt   = state;
        dir_nxt     = dir;
        src_nxt     = src;
        dst_nxt     = dst;
        idx_nxt     = idx;
        busy_nxt    = busy;
        irq_nxt     = 1'b0;
        overrun_nxt = cmd_overrun | (cmd_rise & (state != IDLE));
        issue_rd    = 1'b0;
        issue_wr    = 1'b0;
        op_dir      = dir;
        op_addr     = '0;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = READ;
                    dir_nxt   = read_write_command;
                    src_nxt   = read_address;
                    dst_nxt   = write_address;
                    idx_nxt   = '0;
                    busy_nxt  = 1'b1;
                    issue_rd  = 1'b1;
                    op_dir    = read_write_command;
                    op_addr   = read_address;
                end
            end
            READ: begin
                state_nxt = WRITE;
                issue_wr  = 1'b1;
                op_addr   = dst + ADDR_W'(idx);
            end
            WRITE: begin
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                    irq_nxt   = 1'b1;
                end else begin
                    state_nxt = READ;
                    idx_nxt   = idx + IDX_W'(1);
                    issue_rd  = 1'b1;
                    op_addr   = src + ADDR_W'(idx) + ADDR_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase

        // dir=0 reads outer and writes inner; dir=1 the reverse.
        outer_re_nxt   = issue_rd & ~op_dir;
        inner_re_nxt   = issue_rd & op_dir;
        inner_we_nxt   = issue_wr & ~op_dir;
        outer_we_nxt   = issue_wr & op_dir;
        outer_addr_nxt = (outer_re_nxt | outer_we_nxt) ? op_addr : outer_ram_addr;
        inner_addr_nxt = (inner_re_nxt | inner_we_nxt) ? op_addr : inner_ram_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            cmd_prev              <= 1'b0;
            dir                   <= 1'b0;
            src                   <= '0;
            dst                   <= '0;
            idx                   <= '0;
            busy                  <= 1'b0;
            interupt_ram_transfer <= 1'b0;
            cmd_overrun           <= 1'b0;
            outer_ram_addr        <= '0;
            outer_ram_re          <= 1'b0;
            outer_ram_we          <= 1'b0;
            inner_ram_addr        <= '0;
            inner_ram_re          <= 1'b0;
            inner_ram_we          <= 1'b0;
            wdata_q               <= '0;
        end else begin
            state                 <= state_nxt;
            cmd_prev              <= cmd_transfer;
            dir                   <= dir_nxt;
            src                   <= src_nxt;
            dst                   <= dst_nxt;
            idx                   <= idx_nxt;
            busy                  <= busy_nxt;
            interupt_ram_transfer <= irq_nxt;
            cmd_overrun           <= overrun_nxt;
            outer_ram_addr        <= outer_addr_nxt;
            outer_ram_re          <= outer_re_nxt;
            outer_ram_we          <= outer_we_nxt;
            inner_ram_addr        <= inner_addr_nxt;
            inner_ram_re          <= inner_re_nxt;
            inner_ram_we          <= inner_we_nxt;
            if (state == WRITE) begin
                wdata_q <= src_rdata;
            end
        end
    end

endmodule
